alu_serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor for the ALU. It processes WIDTH-bit operands DIGIT bits per clock, LSB digit first, using a registered carry between digits. A start/busy/done handshake lets wide operands share a narrow adder slice. Results and flags are held until the next accepted operation.

---
 rtl/alu_serial_adder.sv | 123 ++++++++++++
 tb/tb_alu_serial_adder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are summed DIGIT bits per clock,
// LSB digit first, through a registered carry, with a start/busy/done handshake.
module alu_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic [DIGIT:0]   digitSum;
  logic             lastDigit;

  assign digitSum  = {1'b0, aSh_q[DIGIT-1:0]} + {1'b0, bSh_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};
  assign lastDigit = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      aSh_q      <= '0;
      bSh_q      <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      aSh_q      <= aSh_d;
      bSh_q      <= bSh_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  // Subtraction is a + ~b + 1: B is inverted on load and the +1 rides in as carry-in.
  always_comb begin
    state_d    = state_q;
    aSh_d      = aSh_q;
    bSh_d      = bSh_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          aSh_d   = a;
          bSh_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        aSh_d   = aSh_q >> DIGIT;
        bSh_d   = bSh_q >> DIGIT;
        carry_d = digitSum[DIGIT];
        acc_d   = (acc_q >> DIGIT) | (WIDTH'(digitSum[DIGIT-1:0]) << (WIDTH - DIGIT));
        cnt_d   = cnt_q + CW'(1);
        // On the last digit the low DIGIT bits of A/B are the operand MSB digit,
        // so sign overflow is "equal operand signs, different result sign".
        if (lastDigit) begin
          state_d    = DONE;
          result_d   = acc_d;
          cout_d     = digitSum[DIGIT];
          overflow_d = (aSh_q[DIGIT-1] == bSh_q[DIGIT-1]) &&
                       (digitSum[DIGIT-1] != aSh_q[DIGIT-1]);
          zero_d     = (acc_d == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_alu_serial_adder.sv
// Scoreboard bench for alu_serial_adder: four parameterisations share one clock,
// expectations are queued at issue time and retired by a monitor on each done pulse.
module tb_alu_serial_adder;

  typedef struct {
    int          dut;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          accEdge;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  startV;
  logic        subS;
  logic [31:0] aS, bS;
  logic [3:0]  busyV, doneV, coutV, ovfV, zeroV;
  logic [15:0] r0, r1, r2;
  logic [31:0] r3;

  exp_t sbQ[$];
  int   compared;
  int   mismatched;
  int   edges;

  alu_serial_adder #(.WIDTH(16), .DIGIT(4)) u0 (
    .clk(clk), .rst(rst), .start(startV[0]), .sub(subS), .a(aS[15:0]), .b(bS[15:0]),
    .busy(busyV[0]), .done(doneV[0]), .result(r0), .cout(coutV[0]),
    .overflow(ovfV[0]), .zero(zeroV[0]));

  alu_serial_adder #(.WIDTH(16), .DIGIT(16)) u1 (
    .clk(clk), .rst(rst), .start(startV[1]), .sub(subS), .a(aS[15:0]), .b(bS[15:0]),
    .busy(busyV[1]), .done(doneV[1]), .result(r1), .cout(coutV[1]),
    .overflow(ovfV[1]), .zero(zeroV[1]));

  alu_serial_adder #(.WIDTH(16), .DIGIT(1)) u2 (
    .clk(clk), .rst(rst), .start(startV[2]), .sub(subS), .a(aS[15:0]), .b(bS[15:0]),
    .busy(busyV[2]), .done(doneV[2]), .result(r2), .cout(coutV[2]),
    .overflow(ovfV[2]), .zero(zeroV[2]));

  alu_serial_adder #(.WIDTH(32), .DIGIT(8)) u3 (
    .clk(clk), .rst(rst), .start(startV[3]), .sub(subS), .a(aS), .b(bS),
    .busy(busyV[3]), .done(doneV[3]), .result(r3), .cout(coutV[3]),
    .overflow(ovfV[3]), .zero(zeroV[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edges++;

  function automatic int nOf(input int k);
    case (k)
      0: return 4;
      1: return 1;
      2: return 16;
      default: return 4;
    endcase
  endfunction

  function automatic int widthOf(input int k);
    return (k == 3) ? 32 : 16;
  endfunction

  function automatic logic [31:0] resOf(input int k);
    case (k)
      0: return {16'h0, r0};
      1: return {16'h0, r1};
      2: return {16'h0, r2};
      default: return r3;
    endcase
  endfunction

  function automatic exp_t mk(input logic [31:0] res, input logic c, input logic o,
                              input logic z);
    exp_t e;
    e.dut = 0; e.res = res; e.cout = c; e.ovf = o; e.zero = z; e.accEdge = 0; e.lat = 0;
    return e;
  endfunction

  // Reference arithmetic done in 64 bits so the carry out of any width is just bit w.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic s);
    logic [63:0] mask, aa, bb, sum;
    exp_t e;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'h0, a} & mask;
    bb   = (s ? ~{32'h0, b} : {32'h0, b}) & mask;
    sum  = aa + bb + {63'h0, s};
    e    = mk(sum[31:0] & mask[31:0], sum[w], 1'b0, 1'b0);
    e.ovf  = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
    e.zero = ((sum & mask) == 64'h0);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic applyStimulus(input int k, input logic [31:0] a, input logic [31:0] b,
                               input logic s, input exp_t e);
    int t;
    t = 0;
    while (busyV[k] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busyV[k]) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL dut%0d busy_timeout: busy still 1, expected 0", k);
    end
    aS = a; bS = b; subS = s;
    startV[k] = 1'b1;
    e.dut = k;
    e.accEdge = edges + 1;
    e.lat = nOf(k);
    sbQ.push_back(e);
    @(negedge clk);
    startV[k] = 1'b0;
  endtask

  task automatic drain(input int limit);
    int t;
    t = 0;
    while (sbQ.size() != 0 && t < limit) begin
      @(negedge clk);
      t++;
    end
  endtask

  always @(negedge clk) begin
    int   idx;
    exp_t e;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (doneV[k]) begin
          idx = -1;
          for (int i = 0; i < sbQ.size(); i++)
            if (idx < 0 && sbQ[i].dut == k) idx = i;
          if (idx < 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL dut%0d unexpected_done: done=1, expected no completion", k);
          end else begin
            e = sbQ[idx];
            sbQ.delete(idx);
            checkOutput($sformatf("dut%0d result", k), resOf(k), e.res);
            checkOutput($sformatf("dut%0d cout", k), {31'h0, coutV[k]}, {31'h0, e.cout});
            checkOutput($sformatf("dut%0d overflow", k), {31'h0, ovfV[k]}, {31'h0, e.ovf});
            checkOutput($sformatf("dut%0d zero", k), {31'h0, zeroV[k]}, {31'h0, e.zero});
            checkOutput($sformatf("dut%0d latency", k), edges - e.accEdge, e.lat);
            checkOutput($sformatf("dut%0d busy_with_done", k), {31'h0, busyV[k]}, 32'h0);
          end
        end
      end
    end
  end

  initial begin
    int       bc;
    logic [31:0] ra, rb;
    logic     rs;
    compared = 0; mismatched = 0; edges = 0;
    startV = '0; subS = 1'b0; aS = '0; bS = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("reset busy", {31'h0, busyV[0]}, 32'h0);
    checkOutput("reset done", {31'h0, doneV[0]}, 32'h0);
    checkOutput("reset result", {16'h0, r0}, 32'h0);
    checkOutput("reset cout", {31'h0, coutV[0]}, 32'h0);
    checkOutput("reset overflow", {31'h0, ovfV[0]}, 32'h0);
    checkOutput("reset zero", {31'h0, zeroV[0]}, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // Carry ripples across all four digits; busy must last exactly N cycles.
    applyStimulus(0, 32'h0FFF, 32'h0001, 1'b0, mk(32'h1000, 1'b0, 1'b0, 1'b0));
    bc = 0;
    while (busyV[0] && bc < 20) begin
      bc++;
      @(negedge clk);
    end
    checkOutput("busy_cycles", bc, 4);
    drain(50);

    applyStimulus(0, 32'h0005, 32'h0005, 1'b1, mk(32'h0000, 1'b1, 1'b0, 1'b1));
    applyStimulus(0, 32'h0003, 32'h0004, 1'b1, mk(32'hFFFF, 1'b0, 1'b0, 1'b0));
    applyStimulus(0, 32'h7FFF, 32'h0001, 1'b0, mk(32'h8000, 1'b0, 1'b1, 1'b0));
    applyStimulus(0, 32'hFFFF, 32'h0001, 1'b0, mk(32'h0000, 1'b1, 1'b0, 1'b1));
    applyStimulus(0, 32'h8000, 32'h0001, 1'b1, mk(32'h7FFF, 1'b1, 1'b1, 1'b0));
    drain(50);

    // A second start mid-RUN with new operands must be dropped.
    applyStimulus(0, 32'h1234, 32'h1111, 1'b0, mk(32'h2345, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    aS = 32'hFFFF; bS = 32'hFFFF; subS = 1'b1;
    startV[0] = 1'b1;
    @(negedge clk);
    startV[0] = 1'b0;
    drain(50);

    // Start held high: accepts land on each DONE edge, N+1 edges apart.
    aS = 32'h0100; bS = 32'h0023; subS = 1'b0;
    startV[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e = mk(32'h0123, 1'b0, 1'b0, 1'b0);
      e.dut = 0;
      e.accEdge = edges + 1 + i * 5;
      e.lat = 4;
      sbQ.push_back(e);
    end
    repeat (11) @(negedge clk);
    startV[0] = 1'b0;
    drain(50);

    // Asynchronous reset after the second digit edge clears everything at once.
    aS = 32'h4321; bS = 32'h1111; subS = 1'b0;
    startV[0] = 1'b1;
    @(negedge clk);
    startV[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst busy", {31'h0, busyV[0]}, 32'h0);
    checkOutput("midrst done", {31'h0, doneV[0]}, 32'h0);
    checkOutput("midrst result", {16'h0, r0}, 32'h0);
    checkOutput("midrst zero", {31'h0, zeroV[0]}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 32'h00FF, 32'h0F01, 1'b0, mk(32'h1000, 1'b0, 1'b0, 1'b0));
    drain(50);

    for (int k = 1; k < 4; k++) begin
      applyStimulus(k, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
                    model(widthOf(k), 32'h7FFF_FFFF, 32'h0000_0001, 1'b0));
      applyStimulus(k, 32'h0000_0000, 32'h0000_0001, 1'b1,
                    model(widthOf(k), 32'h0000_0000, 32'h0000_0001, 1'b1));
      for (int j = 0; j < 5; j++) begin
        ra = $urandom;
        rb = $urandom;
        rs = 1'($urandom_range(0, 1));
        applyStimulus(k, ra, rb, rs, model(widthOf(k), ra, rb, rs));
      end
      drain(100);
    end

    drain(600);
    while (sbQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL dut%0d completion_timeout: no done, expected result %0h",
               sbQ[0].dut, sbQ[0].res);
      void'(sbQ.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
